alu_operand_sequencer: RTL

Upstream control stage for the 4-bit ALU. Collects operand A, operand B and the 3-bit operation select from a shared 4-bit switch bus, one load press each, and drives them onto the ALU inputs. It captures the ALU's combinational result into a registered output with a zero flag. A chain mode feeds the last result back as the next operand A for accumulator-style calculation.

---
 rtl/alu_operand_sequencer_pkg.sv | 32 +++
 rtl/alu_operand_sequencer_press_detect.sv | 33 +++
 rtl/alu_operand_sequencer.sv | 93 +++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer: FSM state encoding,
// ALU opcode constants and the state-to-display-stage mapping.
package alu_operand_sequencer_pkg;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NONE = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    // EXEC and DONE share the last display stage.
    function automatic logic [1:0] stage_of(state_t s);
        case (s)
            GET_A:   return 2'd0;
            GET_B:   return 2'd1;
            GET_OP:  return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_press_detect.sv
// Turns the debounced load level into a single-cycle press pulse on each
// 0->1 transition; a level already high after reset or clear is not a press.
module press_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic level,
    output logic pulse
);

    logic level_q;
    logic armed;

    // armed stays low for the first sample after reset/clear, so a level
    // that is already high at that point is absorbed into level_q silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            armed   <= 1'b0;
        end else if (clr) begin
            level_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            level_q <= level;
            armed   <= 1'b1;
        end
    end

    assign pulse = level & ~level_q & armed;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects operand A, operand B and opcode from a shared switch bus, drives
// them to the ALU and captures its result with a zero flag; supports chaining.
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             clear,
    input  logic             chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_s,
    input  logic [WIDTH-1:0] alu_y,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             done,
    output logic [1:0]       stage
);

    state_t state;
    state_t state_next;
    logic   press;

    press_detect u_press_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .level (load),
        .pulse (press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= GET_A;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch
        // is inferred.
        state_next = state;
        if (clear) begin
            state_next = GET_A;
        end else begin
            case (state)
                GET_A:   if (press) state_next = GET_B;
                GET_B:   if (press) state_next = GET_OP;
                GET_OP:  if (press) state_next = EXEC;
                EXEC:    state_next = DONE;
                DONE:    if (press) state_next = GET_B;
                default: state_next = GET_A;
            endcase
        end
    end

    // Operand registers only change on presses, so they are stable through
    // EXEC and alu_y gets a full period to settle before capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_s  <= OP_AND;
            result <= '0;
            zero   <= 1'b0;
        end else if (clear) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_s  <= OP_AND;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            case (state)
                GET_A:   if (press) alu_a <= din;
                GET_B:   if (press) alu_b <= din;
                GET_OP:  if (press) alu_s <= din[SEL_W-1:0];
                EXEC: begin
                    result <= alu_y;
                    zero   <= (alu_y == '0);
                end
                DONE:    if (press) alu_a <= chain ? result : din;
                default: ;
            endcase
        end
    end

    assign done  = (state == DONE);
    assign stage = stage_of(state);

endmodule
